// File: rtl/tmu2_fifo256to64_mem.sv
// ============================================================================
// Module   : tmu2_fifo256to64_mem
// Brief    : Storage for tmu2_fifo256to64. Four 64-bit banks share one
//            256-bit write port. Reads are asynchronous, 64 bits at a time.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tmu2_fifo256to64_mem #(
    parameter int depth = 2
) (
    input  logic             clk,
    input  logic             we,
    input  logic [depth-1:0] waddr,
    input  logic [255:0]     wd,
    input  logic [depth-1:0] raddr,
    input  logic [1:0]       rsel,
    output logic [63:0]      rd
);

    logic [63:0] w_q [4];

    // Bank 0 holds the most significant quarter, so it is read out first.
    for (genvar b = 0; b < 4; b++) begin : g_bank
        logic [63:0] r_mem [0:(1<<depth)-1];

        always_ff @(posedge clk) begin
            if (we) begin
                r_mem[waddr] <= wd[255-64*b -: 64];
            end
        end

        assign w_q[b] = r_mem[raddr];
    end

    assign rd = w_q[rsel];

endmodule

`default_nettype wire

// File: rtl/tmu2_fifo256to64.sv
// ============================================================================
// Module   : tmu2_fifo256to64
// Brief    : FIFO that takes 256-bit words and returns 64-bit words, most
//            significant quarter first. Defining TMU2_FIFO256TO64_ERR_EN adds
//            sticky overflow and underflow flags with a clear input.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tmu2_fifo256to64 #(
    parameter int depth = 2
) (
    input  logic          sys_clk,
    input  logic          sys_rst_n,
`ifdef TMU2_FIFO256TO64_ERR_EN
    input  logic          err_clr,
    output logic          ovf,
    output logic          unf,
`endif
    output logic          wavail,
    input  logic          we,
    input  logic [255:0]  wd,
    output logic          ravail,
    output logic          r4avail,
    input  logic          re,
    output logic [63:0]   rd
);

    localparam int               c_capacity = 4 << depth;
    localparam logic [depth+2:0] c_wlimit   = (depth+3)'(c_capacity - 4);
    localparam logic [depth+2:0] c_one      = (depth+3)'(1);
    localparam logic [depth+2:0] c_three    = (depth+3)'(3);
    localparam logic [depth+2:0] c_four     = (depth+3)'(4);

    logic [depth+2:0] r_level;
    logic [depth-1:0] r_produce;
    logic [depth+1:0] r_consume;
    logic             w_write;
    logic             w_read;

    assign wavail  = (r_level <= c_wlimit);
    assign ravail  = (r_level != '0);
    assign r4avail = (r_level >= c_four);

    // Both requests are qualified on the level before the edge, so a read
    // never makes room for a write in the same cycle.
    assign w_write = we & wavail;
    assign w_read  = re & ravail;

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            r_level   <= '0;
            r_produce <= '0;
            r_consume <= '0;
        end else begin
            if (w_write) begin
                r_produce <= r_produce + depth'(1);
            end
            if (w_read) begin
                r_consume <= r_consume + (depth+2)'(1);
            end
            case ({w_write, w_read})
                2'b10:   r_level <= r_level + c_four;
                2'b01:   r_level <= r_level - c_one;
                2'b11:   r_level <= r_level + c_three;
                default: r_level <= r_level;
            endcase
        end
    end

    tmu2_fifo256to64_mem #(
        .depth (depth)
    ) u_mem (
        .clk   (sys_clk),
        .we    (w_write),
        .waddr (r_produce),
        .wd    (wd),
        .raddr (r_consume[depth+1:2]),
        .rsel  (r_consume[1:0]),
        .rd    (rd)
    );

`ifdef TMU2_FIFO256TO64_ERR_EN
    logic r_ovf;
    logic r_unf;

    // A set event wins over a simultaneous clear.
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            r_ovf <= 1'b0;
            r_unf <= 1'b0;
        end else begin
            if (we & ~wavail) begin
                r_ovf <= 1'b1;
            end else if (err_clr) begin
                r_ovf <= 1'b0;
            end
            if (re & ~ravail) begin
                r_unf <= 1'b1;
            end else if (err_clr) begin
                r_unf <= 1'b0;
            end
        end
    end

    assign ovf = r_ovf;
    assign unf = r_unf;
`endif

endmodule

`default_nettype wire

// File: tb/tb_tmu2_fifo256to64.sv
// ============================================================================
// Module   : tb_tmu2_fifo256to64
// Brief    : Directed self-checking bench for tmu2_fifo256to64 (depth=2).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_tmu2_fifo256to64;

    localparam int DEPTH = 2;
    localparam int WLIM  = (4 << DEPTH) - 4;

    logic          sys_clk   = 1'b0;
    logic          sys_rst_n = 1'b0;
    logic          we        = 1'b0;
    logic          re        = 1'b0;
    logic [255:0]  wd        = '0;
    logic          wavail;
    logic          ravail;
    logic          r4avail;
    logic [63:0]   rd;
`ifdef TMU2_FIFO256TO64_ERR_EN
    logic          err_clr   = 1'b0;
    logic          ovf;
    logic          unf;
`endif

    int n_chk  = 0;
    int n_pass = 0;
    logic [63:0] mq[$];

    always #5 sys_clk = ~sys_clk;

    tmu2_fifo256to64 #(.depth(DEPTH)) dut (
        .sys_clk   (sys_clk),
        .sys_rst_n (sys_rst_n),
`ifdef TMU2_FIFO256TO64_ERR_EN
        .err_clr   (err_clr),
        .ovf       (ovf),
        .unf       (unf),
`endif
        .wavail    (wavail),
        .we        (we),
        .wd        (wd),
        .ravail    (ravail),
        .r4avail   (r4avail),
        .re        (re),
        .rd        (rd)
    );

    function automatic logic [255:0] pat(input logic [63:0] b);
        return {b + 64'd3, b + 64'd2, b + 64'd1, b};
    endfunction

    // One clock with the given requests; the reference queue follows the
    // acceptance rules of the FIFO.
    task automatic step(input logic w, input logic [255:0] d, input logic r);
        bit wok;
        bit rok;
        wok = w && (mq.size() <= WLIM);
        rok = r && (mq.size() != 0);
        we = w; wd = d; re = r;
        @(posedge sys_clk); #1;
        we = 1'b0; re = 1'b0;
        if (rok) void'(mq.pop_front());
        if (wok) begin
            mq.push_back(d[255:192]);
            mq.push_back(d[191:128]);
            mq.push_back(d[127:64]);
            mq.push_back(d[63:0]);
        end
    endtask

    task automatic drain(output int cnt, output int bad);
        cnt = 0; bad = 0;
        while (ravail === 1'b1 && cnt < 200) begin
            if (mq.size() == 0 || rd !== mq[0]) bad++;
            step(1'b0, '0, 1'b1);
            cnt++;
        end
    endtask

    task automatic do_reset();
        sys_rst_n = 1'b0;
        repeat (2) @(posedge sys_clk);
        #1;
        sys_rst_n = 1'b1;
        mq.delete();
    endtask

    task automatic test_reset();
        sys_rst_n = 1'b0;
        repeat (2) @(posedge sys_clk);
        #1;
        n_chk++; if (wavail !== 1'b1) $display("FAIL reset_wavail got=%b exp=1", wavail); else n_pass++;
        n_chk++; if (ravail !== 1'b0) $display("FAIL reset_ravail got=%b exp=0", ravail); else n_pass++;
        n_chk++; if (r4avail !== 1'b0) $display("FAIL reset_r4avail got=%b exp=0", r4avail); else n_pass++;
        sys_rst_n = 1'b1;
        mq.delete();
        step(1'b0, '0, 1'b1);
        n_chk++; if (ravail !== 1'b0) $display("FAIL reset_read_empty ravail got=%b exp=0", ravail); else n_pass++;
    endtask

    task automatic test_order();
        step(1'b1, pat(64'd0), 1'b0);
        n_chk++; if (ravail !== 1'b1) $display("FAIL order_ravail_after_write got=%b exp=1", ravail); else n_pass++;
        n_chk++; if (r4avail !== 1'b1) $display("FAIL order_r4avail got=%b exp=1", r4avail); else n_pass++;
        for (int i = 0; i < 4; i++) begin
            n_chk++;
            if (rd !== 64'(3 - i)) $display("FAIL order_rd%0d got=%h exp=%h", i, rd, 64'(3 - i));
            else n_pass++;
            step(1'b0, '0, 1'b1);
            if (i == 0) begin
                n_chk++; if (r4avail !== 1'b0) $display("FAIL order_r4avail_3left got=%b exp=0", r4avail); else n_pass++;
            end
        end
        n_chk++; if (ravail !== 1'b0) $display("FAIL order_ravail_end got=%b exp=0", ravail); else n_pass++;
    endtask

    task automatic test_full();
        int cnt, bad;
        for (int i = 1; i <= 4; i++) begin
            step(1'b1, pat(64'(i * 16)), 1'b0);
            if (i == 3) begin
                n_chk++; if (wavail !== 1'b1) $display("FAIL full_wavail_lvl12 got=%b exp=1", wavail); else n_pass++;
            end
        end
        n_chk++; if (wavail !== 1'b0) $display("FAIL full_wavail_lvl16 got=%b exp=0", wavail); else n_pass++;
        step(1'b1, pat(64'h99), 1'b0);
        n_chk++; if (rd !== 64'h13) $display("FAIL full_head_intact got=%h exp=13", rd); else n_pass++;
        step(1'b0, '0, 1'b1);
        n_chk++; if (wavail !== 1'b0) $display("FAIL full_wavail_lvl15 got=%b exp=0", wavail); else n_pass++;
        n_chk++; if (rd !== 64'h12) $display("FAIL full_rd_second got=%h exp=12", rd); else n_pass++;
        step(1'b0, '0, 1'b1);
        step(1'b0, '0, 1'b1);
        n_chk++; if (wavail !== 1'b0) $display("FAIL full_wavail_lvl13 got=%b exp=0", wavail); else n_pass++;
        step(1'b0, '0, 1'b1);
        n_chk++; if (wavail !== 1'b1) $display("FAIL full_wavail_lvl12b got=%b exp=1", wavail); else n_pass++;
        drain(cnt, bad);
        n_chk++; if (cnt !== 12) $display("FAIL full_drain_count got=%0d exp=12", cnt); else n_pass++;
        n_chk++; if (bad !== 0) $display("FAIL full_drain_data bad=%0d exp=0", bad); else n_pass++;
    endtask

    task automatic test_simultaneous();
        int cnt, bad;
        step(1'b1, pat(64'h100), 1'b0);
        step(1'b1, pat(64'h200), 1'b0);
        step(1'b1, pat(64'h300), 1'b1);
        n_chk++; if (wavail !== 1'b1) $display("FAIL simul_wavail_lvl11 got=%b exp=1", wavail); else n_pass++;
        drain(cnt, bad);
        n_chk++; if (cnt !== 11) $display("FAIL simul_lvl11_count got=%0d exp=11", cnt); else n_pass++;
        n_chk++; if (bad !== 0) $display("FAIL simul_lvl11_data bad=%0d exp=0", bad); else n_pass++;
        for (int i = 0; i < 4; i++) step(1'b1, pat(64'(16'h400 + i * 16)), 1'b0);
        for (int i = 0; i < 3; i++) step(1'b0, '0, 1'b1);
        step(1'b1, pat(64'h500), 1'b1);
        n_chk++; if (wavail !== 1'b1) $display("FAIL simul_wavail_lvl12 got=%b exp=1", wavail); else n_pass++;
        drain(cnt, bad);
        n_chk++; if (cnt !== 12) $display("FAIL simul_lvl12_count got=%0d exp=12", cnt); else n_pass++;
        n_chk++; if (bad !== 0) $display("FAIL simul_lvl12_data bad=%0d exp=0", bad); else n_pass++;
    endtask

    task automatic test_stream();
        int reads = 0;
        int bad   = 0;
        int cnt, bad2;
        for (int k = 0; k < 64; k++) begin
            if (ravail === 1'b1) begin
                reads++;
                if (mq.size() == 0 || rd !== mq[0]) bad++;
            end
            if (ravail !== (mq.size() != 0)) bad++;
            step((k % 4) == 0, pat(64'(32'h1000 + k * 4)), 1'b1);
        end
        drain(cnt, bad2);
        n_chk++; if (reads + cnt !== 64) $display("FAIL stream_count got=%0d exp=64", reads + cnt); else n_pass++;
        n_chk++; if (bad + bad2 !== 0) $display("FAIL stream_data bad=%0d exp=0", bad + bad2); else n_pass++;
    endtask

    task automatic test_reset_mid();
        step(1'b1, pat(64'h700), 1'b0);
        step(1'b1, pat(64'h800), 1'b0);
        step(1'b0, '0, 1'b1);
        step(1'b0, '0, 1'b1);
        #2;
        sys_rst_n = 1'b0;
        #1;
        n_chk++; if (wavail !== 1'b1) $display("FAIL rstmid_wavail got=%b exp=1", wavail); else n_pass++;
        n_chk++; if (ravail !== 1'b0) $display("FAIL rstmid_ravail got=%b exp=0", ravail); else n_pass++;
        n_chk++; if (r4avail !== 1'b0) $display("FAIL rstmid_r4avail got=%b exp=0", r4avail); else n_pass++;
        @(posedge sys_clk); #1;
        sys_rst_n = 1'b1;
        mq.delete();
        step(1'b1, pat(64'hA00), 1'b0);
        n_chk++; if (rd !== 64'hA03) $display("FAIL rstmid_newdata got=%h exp=a03", rd); else n_pass++;
        n_chk++; if (r4avail !== 1'b1) $display("FAIL rstmid_level4 got=%b exp=1", r4avail); else n_pass++;
        do_reset();
    endtask

`ifdef TMU2_FIFO256TO64_ERR_EN
    task automatic test_err();
        do_reset();
        n_chk++; if (unf !== 1'b0 || ovf !== 1'b0) $display("FAIL err_reset got=%b%b exp=00", ovf, unf); else n_pass++;
        step(1'b0, '0, 1'b1);
        step(1'b0, '0, 1'b0);
        n_chk++; if (unf !== 1'b1) $display("FAIL err_unf_held got=%b exp=1", unf); else n_pass++;
        err_clr = 1'b1;
        step(1'b0, '0, 1'b1);
        n_chk++; if (unf !== 1'b1) $display("FAIL err_unf_set_wins got=%b exp=1", unf); else n_pass++;
        step(1'b0, '0, 1'b0);
        err_clr = 1'b0;
        n_chk++; if (unf !== 1'b0) $display("FAIL err_unf_clr got=%b exp=0", unf); else n_pass++;
        for (int i = 0; i < 4; i++) step(1'b1, pat(64'(i)), 1'b0);
        n_chk++; if (ovf !== 1'b0) $display("FAIL err_ovf_early got=%b exp=0", ovf); else n_pass++;
        step(1'b1, pat(64'hB00), 1'b0);
        n_chk++; if (ovf !== 1'b1) $display("FAIL err_ovf_set got=%b exp=1", ovf); else n_pass++;
        do_reset();
    endtask
`endif

    initial begin
        test_reset();
        test_order();
        test_full();
        test_simultaneous();
        test_stream();
        test_reset_mid();
`ifdef TMU2_FIFO256TO64_ERR_EN
        test_err();
`endif
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/tmu2_fifo256to64.md
TMU2_FIFO256TO64 -- requirements
Module: tmu2_fifo256to64

Interface
REQ-001 SHALL have parameter depth, default 2, log2 of capacity in 256-bit words (capacity 4<<depth 64-bit words).
REQ-002 SHALL have port sys_clk  in  1  system clock; sole clock, all state on rising edge.
REQ-003 SHALL have port sys_rst_n  in  1  asynchronous active-low reset.
REQ-004 SHALL have port wavail  out  1  room for one full 256-bit word.
REQ-005 SHALL have port we  in  1  write request, 256-bit word.
REQ-006 SHALL have port wd  in  256  write data.
REQ-007 SHALL have port ravail  out  1  at least one 64-bit word stored.
REQ-008 SHALL have port r4avail  out  1  at least four 64-bit words stored (burst-read hint).
REQ-009 SHALL have port re  in  1  read request, 64-bit word.
REQ-010 SHALL have port rd  out  64  head-of-FIFO data, combinational from storage, valid while ravail=1.

Function
REQ-011 SHALL keep level (depth+3 bits, unit 64-bit words), produce (depth bits, 256-bit units), consume (depth+2 bits, 64-bit units).
REQ-012 SHALL drive wavail = (level <= (4<<depth)-4); ravail = (level != 0); r4avail = (level >= 4).
REQ-013 SHALL qualify write = we & wavail and read = re & ravail, both on pre-edge level; no same-cycle bypass.
REQ-014 SHALL, on write, store wd[255:192], wd[191:128], wd[127:64], wd[63:0] as 64-bit words 0..3 of slot produce, then increment produce.
REQ-015 SHALL present rd = word consume[1:0] of slot consume[depth+1:2], i.e. MSB quarter first; on read, increment consume.
REQ-016 SHALL update level: read only -1; write only +4; both +3; neither unchanged.
REQ-017 SHALL wrap produce and consume modulo their width without any extra logic.
REQ-018 SHALL ignore we when wavail=0 (no state change, even if read occurs same cycle); SHALL ignore re when ravail=0.
REQ-019 SHALL make a write visible on rd/ravail one cycle after the accepting edge (zero-bubble when empty).
REQ-020 SHALL leave rd undefined while ravail=0.

Reset
REQ-021 SHALL, on sys_rst_n low, asynchronously clear level, produce, consume (wavail=1, ravail=0, r4avail=0); storage not reset.
REQ-022 SHALL, on reset asserted mid-operation, discard all stored data; first cycle after deassertion behaves as empty FIFO.

Configuration
REQ-023 SHALL, with TMU2_FIFO256TO64_ERR_EN defined, add ports err_clr (in, 1) and ovf/unf (out, 1 each): ovf sets on we & ~wavail, unf on re & ~ravail, both sticky until err_clr or reset; err_clr and a set event in the same cycle -> flag set.
REQ-024 SHALL, without TMU2_FIFO256TO64_ERR_EN, omit those ports and logic; behaviour otherwise identical.

Structure
REQ-025 SHALL need no shared package; capacity constants are local to the module.
REQ-026 SHALL place storage in one sub-module tmu2_fifo256to64_mem (four 64-bit banks, 256-bit write port, 64-bit async read port).

Verification
REQ-027 SHALL cover: depth=2, write 0x0..03_0..02_0..01_0..00 pattern, then 4 reads -> rd = 3,2,1,0 words in order, ravail drops after 4th read.
REQ-028 SHALL cover: 4 writes back-to-back from empty -> level 16, wavail=0; 5th write ignored, data intact; one read -> level 15, wavail still 0; 4th read -> wavail=1.
REQ-029 SHALL cover: level 8, simultaneous we and re -> level 11; at level 13 with we & re -> write refused, level 12.
REQ-030 SHALL cover: 64 words streamed continuous read+write at depth=2 -> pointers wrap, output sequence matches input, no loss.
REQ-031 SHALL cover: sys_rst_n pulsed low mid-cycle with level 6 -> wavail=1, ravail=0 immediately, before next clock edge.
REQ-032 SHALL cover (ERR_EN): re on empty -> unf=1 held; err_clr -> unf=0 next cycle; write while full -> ovf=1.
